// File: rtl/rgb_fade_sequencer.sv
// Loops a keyframe table of RGB duty targets, ramping each channel toward the active frame by at most STEP per PWM period, then holding.
// Duties update only on the last cycle of a period (valid from cnt==0); no backpressure, stop freezes the duties and returns to IDLE next cycle.
module rgb_fade_sequencer #(
  parameter int PWM_INTERVAL = 1200,
  parameter int NUM_FRAMES   = 8,
  parameter int STEP         = 12,
  parameter int HOLD_W       = 16,
  localparam int DW = $clog2(PWM_INTERVAL + 1),
  localparam int AW = $clog2(NUM_FRAMES),
  localparam int CW = 3 * DW + HOLD_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_addr,
  input  logic [CW-1:0] cfg_data,
  input  logic [AW-1:0] cfg_last,
  output logic [DW-1:0] duty_r,
  output logic [DW-1:0] duty_g,
  output logic [DW-1:0] duty_b,
  output logic          period_start,
  output logic          busy,
  output logic [AW-1:0] frame_idx
);
  localparam int              CNTW     = (PWM_INTERVAL > 1) ? $clog2(PWM_INTERVAL) : 1;
  localparam logic [CNTW-1:0] CNT_MAX  = CNTW'(PWM_INTERVAL - 1);
  localparam logic [DW-1:0]   DUTY_MAX = DW'(PWM_INTERVAL);
  localparam logic [DW:0]     STEP_W   = (DW + 1)'(STEP);
  localparam logic [AW:0]     LAST_MAX = (AW + 1)'(NUM_FRAMES - 1);

  typedef enum logic [1:0] {IDLE, LOAD, FADE, HOLD} state_e;

  function automatic logic [DW-1:0] clamp(input logic [DW-1:0] v);
    return (v > DUTY_MAX) ? DUTY_MAX : v;
  endfunction

  // Gap is computed one bit wider so a step can never wrap past zero or the top.
  function automatic logic [DW-1:0] approach(input logic [DW-1:0] d, input logic [DW-1:0] t);
    logic [DW:0] gap;
    gap = (d < t) ? ({1'b0, t} - {1'b0, d}) : ({1'b0, d} - {1'b0, t});
    if (gap <= STEP_W) return t;
    return (d < t) ? DW'({1'b0, d} + STEP_W) : DW'({1'b0, d} - STEP_W);
  endfunction

  state_e            state_q, state_d;
  logic [CNTW-1:0]   cnt_q;
  logic              period_start_q;
  logic [CW-1:0]     tbl_q [NUM_FRAMES];
  logic [DW-1:0]     duty_r_q, duty_g_q, duty_b_q;
  logic [DW-1:0]     tgt_r_q, tgt_g_q, tgt_b_q;
  logic [HOLD_W-1:0] hold_cnt_q;
  logic [AW-1:0]     frame_idx_q;
  logic [DW-1:0]     nxt_r, nxt_g, nxt_b;
  logic [AW-1:0]     last_eff, frame_nxt;
  logic [CW-1:0]     entry;
  logic              tick, at_tgt, hold_done;

  assign tick      = (cnt_q == CNT_MAX);
  assign nxt_r     = approach(duty_r_q, tgt_r_q);
  assign nxt_g     = approach(duty_g_q, tgt_g_q);
  assign nxt_b     = approach(duty_b_q, tgt_b_q);
  assign at_tgt    = (nxt_r == tgt_r_q) && (nxt_g == tgt_g_q) && (nxt_b == tgt_b_q);
  assign hold_done = (hold_cnt_q == '0);
  assign last_eff  = ({1'b0, cfg_last} > LAST_MAX) ? LAST_MAX[AW-1:0] : cfg_last;
  // ">=" so a loop shortened below the active frame restarts at frame 0.
  assign frame_nxt = (frame_idx_q >= last_eff) ? '0 : frame_idx_q + 1'b1;
  assign entry     = tbl_q[frame_idx_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q          <= '0;
      period_start_q <= 1'b0;
    end else begin
      cnt_q          <= tick ? '0 : cnt_q + 1'b1;
      period_start_q <= tick;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_FRAMES; i++) tbl_q[i] <= '0;
    end else if (cfg_we) begin
      tbl_q[cfg_addr] <= {cfg_data[CW-1 -: HOLD_W], clamp(cfg_data[3*DW-1 -: DW]),
                          clamp(cfg_data[2*DW-1 -: DW]), clamp(cfg_data[DW-1:0])};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (stop) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start) state_d = LOAD;
        LOAD:    state_d = FADE;
        FADE:    if (tick && at_tgt) state_d = HOLD;
        HOLD:    if (tick && hold_done) state_d = LOAD;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state_q != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_r_q    <= '0;
      duty_g_q    <= '0;
      duty_b_q    <= '0;
      tgt_r_q     <= '0;
      tgt_g_q     <= '0;
      tgt_b_q     <= '0;
      hold_cnt_q  <= '0;
      frame_idx_q <= '0;
    end else if (!stop) begin
      case (state_q)
        IDLE: if (start) frame_idx_q <= '0;
        LOAD: begin
          tgt_r_q    <= entry[3*DW-1 -: DW];
          tgt_g_q    <= entry[2*DW-1 -: DW];
          tgt_b_q    <= entry[DW-1:0];
          hold_cnt_q <= entry[CW-1 -: HOLD_W];
        end
        FADE: if (tick) begin
          duty_r_q <= nxt_r;
          duty_g_q <= nxt_g;
          duty_b_q <= nxt_b;
        end
        HOLD: if (tick) begin
          if (hold_done) frame_idx_q <= frame_nxt;
          else           hold_cnt_q  <= hold_cnt_q - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign duty_r       = duty_r_q;
  assign duty_g       = duty_g_q;
  assign duty_b       = duty_b_q;
  assign period_start = period_start_q;
  assign frame_idx    = frame_idx_q;

endmodule
